// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
//   state_e : occupancy FSM states
//   ctrl_t  : pipeline-register control bundle driven to the datapath
//   CTRL_*  : canonical control patterns for each hazard response
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_flush;
    logic id_flush;
    logic ex_flush;
  } ctrl_t;

  // Bit order: pc_write, if_id_write, id_ex_write, if_flush, id_flush, ex_flush
  localparam ctrl_t CTRL_RUN      = 6'b111_000;
  // Load-use: freeze PC and IF/ID, let ID/EX load a bubble.
  localparam ctrl_t CTRL_STALL_LU = 6'b001_010;
  // MUL/DIV occupancy: freeze front end, keep EX/MEM from capturing.
  localparam ctrl_t CTRL_STALL_MD = 6'b000_001;
  // Taken branch: PC loads target, squash the three younger stages.
  localparam ctrl_t CTRL_FLUSH_BR = 6'b111_111;
  localparam ctrl_t CTRL_RESET    = 6'b000_111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears count
//   inc_i   : increment request (ignored once count is all-ones)
//   clr_i   : synchronous clear, wins over inc_i
//   count_o : current count
module sat_counter #(
  parameter int PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [PERF_W-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {PERF_W{1'b1}})) begin
      count_o <= count_o + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush controller for the 5-stage pipeline. Merges load-use, taken
// branch and multi-cycle MUL/DIV occupancy into one set of pipeline-register
// controls (Mealy, zero-cycle response) and keeps saturating perf counters.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   load_use_i            : load-use hazard from ID comparator
//   branch_taken_i        : branch in EX resolved taken
//   muldiv_start_i        : MUL/DIV in its first EX cycle
//   perf_clr_i            : clear both perf counters
//   pc_write_o .. ex_flush_o : pipeline register enables / flushes
//   muldiv_busy_o         : FSM in MD_WAIT
//   muldiv_done_o         : MUL/DIV result valid in EX this cycle
//   stall_cycles_o        : cycles with pc_write_o=0
//   flush_events_o        : taken-branch flush cycles
//
// state   | meaning
// RUN     | normal issue; hazards resolved by priority branch > muldiv > load-use
// MD_WAIT | MUL/DIV holds EX; cnt counts remaining cycles, cnt==1 is done cycle
module pipeline_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int CNT_W          = 6,
  parameter int PERF_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_use_i,
  input  logic              branch_taken_i,
  input  logic              muldiv_start_i,
  input  logic              perf_clr_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_write_o,
  output logic              if_flush_o,
  output logic              id_flush_o,
  output logic              ex_flush_o,
  output logic              muldiv_busy_o,
  output logic              muldiv_done_o,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_events_o
);

  localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MULDIV_LATENCY - 1);
  localparam bit               MD_MULTI = (MULDIV_LATENCY > 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic             busy, done, flush_ev, stall_ev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctrl     = CTRL_RUN;
    busy     = 1'b0;
    done     = 1'b0;
    flush_ev = 1'b0;
    if (rst_i) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken_i) begin
            ctrl     = CTRL_FLUSH_BR;
            flush_ev = 1'b1;
          end else if (muldiv_start_i) begin
            if (MD_MULTI) begin
              ctrl    = CTRL_STALL_MD;
              cnt_d   = MD_LOAD;
              state_d = MD_WAIT;
            end else begin
              // Single-cycle MUL/DIV completes in its issue cycle.
              done = 1'b1;
            end
          end else if (load_use_i) begin
            ctrl = CTRL_STALL_LU;
          end
        end
        MD_WAIT: begin
          busy = 1'b1;
          if (cnt_q > CNT_W'(1)) begin
            ctrl  = CTRL_STALL_MD;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            done    = 1'b1;
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall_ev = !rst_i && !ctrl.pc_write;

  assign pc_write_o    = ctrl.pc_write;
  assign if_id_write_o = ctrl.if_id_write;
  assign id_ex_write_o = ctrl.id_ex_write;
  assign if_flush_o    = ctrl.if_flush;
  assign id_flush_o    = ctrl.id_flush;
  assign ex_flush_o    = ctrl.ex_flush;
  assign muldiv_busy_o = busy;
  assign muldiv_done_o = done;

  sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_ev),
    .clr_i   (perf_clr_i),
    .count_o (stall_cycles_o)
  );

  sat_counter #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_ev),
    .clr_i   (perf_clr_i),
    .count_o (flush_events_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: one instance with latency 4 and one
// with latency 1 share the same stimulus and are checked against a
// cycle-level reference model plus a hand-derived vector table.
module tb_pipeline_hazard_sequencer;

  localparam int PERF_W = 16;
  localparam int PMAX   = (1 << PERF_W) - 1;

  logic clk_i = 1'b0;
  logic rst_i, load_use_i, branch_taken_i, muldiv_start_i, perf_clr_i;

  logic a_pc, a_ifid, a_idex, a_iff, a_idf, a_exf, a_busy, a_done;
  logic b_pc, b_ifid, b_idex, b_iff, b_idf, b_exf, b_busy, b_done;
  logic [PERF_W-1:0] a_stall, a_flush, b_stall, b_flush;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_sequencer #(.MULDIV_LATENCY(4), .CNT_W(6), .PERF_W(PERF_W)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .load_use_i(load_use_i),
    .branch_taken_i(branch_taken_i), .muldiv_start_i(muldiv_start_i),
    .perf_clr_i(perf_clr_i), .pc_write_o(a_pc), .if_id_write_o(a_ifid),
    .id_ex_write_o(a_idex), .if_flush_o(a_iff), .id_flush_o(a_idf),
    .ex_flush_o(a_exf), .muldiv_busy_o(a_busy), .muldiv_done_o(a_done),
    .stall_cycles_o(a_stall), .flush_events_o(a_flush)
  );

  pipeline_hazard_sequencer #(.MULDIV_LATENCY(1), .CNT_W(6), .PERF_W(PERF_W)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .load_use_i(load_use_i),
    .branch_taken_i(branch_taken_i), .muldiv_start_i(muldiv_start_i),
    .perf_clr_i(perf_clr_i), .pc_write_o(b_pc), .if_id_write_o(b_ifid),
    .id_ex_write_o(b_idex), .if_flush_o(b_iff), .id_flush_o(b_idf),
    .ex_flush_o(b_exf), .muldiv_busy_o(b_busy), .muldiv_done_o(b_done),
    .stall_cycles_o(b_stall), .flush_events_o(b_flush)
  );

  // Expected-output encoding: {pc, if_id, id_ex, if_fl, id_fl, ex_fl, busy, done}
  localparam logic [7:0] E_RESET = 8'b000_111_00;
  localparam logic [7:0] E_RUN   = 8'b111_000_00;
  localparam logic [7:0] E_LU    = 8'b001_010_00;
  localparam logic [7:0] E_MDST  = 8'b000_001_00;
  localparam logic [7:0] E_BR    = 8'b111_111_00;

  // Reference model: per instance, the number of occupancy cycles still to
  // run after the issue cycle, and event totals.
  int lat [2] = '{4, 1};
  int left_m [2];
  int stall_m [2];
  int flush_m [2];

  function automatic logic [7:0] model_out(int k, logic r, logic lu, logic br, logic md);
    if (r)               return E_RESET;
    if (left_m[k] > 1)   return E_MDST | 8'b10;
    if (left_m[k] == 1)  return E_RUN | 8'b11;
    if (br)              return E_BR;
    if (md)              return (lat[k] > 1) ? E_MDST : (E_RUN | 8'b01);
    if (lu)              return E_LU;
    return E_RUN;
  endfunction

  task automatic check(input string name, input int k, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[inst %0d] t=%0t got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic lu, input logic br, input logic md,
                      input logic clr, input bit use_tbl, input logic [7:0] tbl_exp);
    logic [7:0] exp_o, act_a, act_b;
    @(posedge clk_i);
    #1;
    rst_i = r; load_use_i = lu; branch_taken_i = br; muldiv_start_i = md; perf_clr_i = clr;
    @(negedge clk_i);
    act_a = {a_pc, a_ifid, a_idex, a_iff, a_idf, a_exf, a_busy, a_done};
    act_b = {b_pc, b_ifid, b_idex, b_iff, b_idf, b_exf, b_busy, b_done};
    if (use_tbl) check("table_ctrl", 0, int'(act_a), int'(tbl_exp));
    for (int k = 0; k < 2; k++) begin
      exp_o = model_out(k, r, lu, br, md);
      check("ctrl", k, int'(k == 0 ? act_a : act_b), int'(exp_o));
      check("stall_cycles", k, int'(k == 0 ? a_stall : b_stall), stall_m[k]);
      check("flush_events", k, int'(k == 0 ? a_flush : b_flush), flush_m[k]);
      if (r) begin
        left_m[k] = 0; stall_m[k] = 0; flush_m[k] = 0;
      end else begin
        if (clr) stall_m[k] = 0;
        else if (!exp_o[7] && stall_m[k] < PMAX) stall_m[k]++;
        if (clr) flush_m[k] = 0;
        else if (left_m[k] == 0 && br && flush_m[k] < PMAX) flush_m[k]++;
        if (left_m[k] > 0)                 left_m[k]--;
        else if (!br && md && lat[k] > 1) left_m[k] = lat[k] - 1;
      end
    end
  endtask

  typedef struct {
    logic       r, lu, br, md, clr;
    logic [7:0] exp_a;
  } vec_t;

  vec_t tbl [18];

  initial begin
    rst_i = 1'b1; load_use_i = 1'b0; branch_taken_i = 1'b0;
    muldiv_start_i = 1'b0; perf_clr_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      left_m[k] = 0; stall_m[k] = 0; flush_m[k] = 0;
    end

    // r lu br md clr | expected for latency-4 instance
    tbl[0]  = '{1, 0, 0, 0, 0, E_RESET};
    tbl[1]  = '{0, 0, 0, 0, 0, E_RUN};
    tbl[2]  = '{0, 1, 0, 0, 0, E_LU};
    tbl[3]  = '{0, 0, 0, 0, 0, E_RUN};
    tbl[4]  = '{0, 0, 0, 1, 0, E_MDST};
    tbl[5]  = '{0, 0, 0, 0, 0, 8'b000_001_10};
    tbl[6]  = '{0, 1, 0, 0, 0, 8'b000_001_10};
    tbl[7]  = '{0, 0, 1, 0, 0, 8'b111_000_11};
    tbl[8]  = '{0, 0, 0, 1, 0, E_MDST};
    tbl[9]  = '{0, 0, 0, 0, 0, 8'b000_001_10};
    tbl[10] = '{1, 0, 0, 0, 0, E_RESET};
    tbl[11] = '{0, 0, 0, 0, 0, E_RUN};
    tbl[12] = '{0, 1, 1, 1, 0, E_BR};
    tbl[13] = '{0, 1, 0, 1, 0, E_MDST};
    tbl[14] = '{0, 0, 0, 0, 0, 8'b000_001_10};
    tbl[15] = '{0, 0, 0, 0, 0, 8'b000_001_10};
    tbl[16] = '{0, 0, 0, 0, 0, 8'b111_000_11};
    tbl[17] = '{0, 0, 0, 0, 0, E_RUN};

    for (int i = 0; i < 18; i++)
      step(tbl[i].r, tbl[i].lu, tbl[i].br, tbl[i].md, tbl[i].clr, 1'b1, tbl[i].exp_a);

    // After the table: 1 (load-use) gone by reset, then branch=0 stall,
    // 3 stalls from the last MUL/DIV; one branch flush.
    check("hand_stall_after_table", 0, int'(a_stall), 3);
    check("hand_flush_after_table", 0, int'(a_flush), 1);

    // Saturation: enough load-use cycles to pass all-ones, then clear
    // together with a stall.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < PMAX + 4; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("hand_stall_saturated", 0, int'(a_stall), PMAX);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("hand_stall_cleared", 0, int'(a_stall), 0);

    // Randomized traffic with occasional reset and clear.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 47) == 0,
           1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
